icache_block_param: RTL and testbench
=====================================

Name: icache_block_param

Overview:
Parametrised successor to the single-word, 4-way instruction cache block: a read-only, set-associative L1 instruction cache with multi-word lines, burst refill over the common bus, and an internal tree pseudo-LRU (no external replacement input). It adds a whole-cache flush sequencer. It sits between one processor's fetch port and the shared instruction common bus / arbiter, and handles one outstanding miss at a time.

Parameters:
ADDR_W, 32, address width in bits; byte addressed, 4-byte words
DATA_W, 32, word width
WAYS, 4, associativity; power of 2, ≥2
SETS, 16, number of sets; power of 2
WORDS, 4, words per line; power of 2, ≥1
Derived: OFF_W=log2(WORDS), IDX_W=log2(SETS), TAG_W=ADDR_W-2-OFF_W-IDX_W, WAY_W=max(1,log2(WAYS))

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
PrRd  in  1  processor read request; held until Rd_valid
Address  in  ADDR_W  fetch address: [1:0] ignored, then word offset, index, tag (MSBs)
Flush  in  1  request invalidation of all lines
Data_Bus  out  DATA_W  read data; valid only when Rd_valid=1
Rd_valid  out  1  one-cycle pulse: Data_Bus holds the requested word
CPU_stall  out  1  high while miss or flush is in progress
Blk_accessed  out  WAY_W  way index of the last hit or fill
Com_Bus_Req_proc  out  1  common-bus request to the arbiter
Com_Bus_Gnt_proc  in  1  arbiter grant
Address_Com  out  ADDR_W  refill beat address
Data_Bus_Com  in  DATA_W  refill data
Data_in_Bus  in  1  refill beat valid on Data_Bus_Com

Behaviour:
- Reset (async) clears all valid bits, all pLRU bits, the beat counter and the flush counter. FSM goes to IDLE. All outputs are 0.
- FSM states are IDLE, MISS_REQ, FILL, RESP and FLUSH. Tag and data arrays are not reset.
- IDLE, Flush=1: go to FLUSH. Flush wins over a simultaneous PrRd. CPU_stall goes to 1 on the next edge.
- IDLE, PrRd=1, hit (valid and tag match in exactly one way):
  - next edge: Data_Bus=word[offset], Rd_valid=1, CPU_stall=0, Blk_accessed=hit way; pLRU for the set is updated toward that way.
  - Hit latency is 1 cycle; back-to-back hits give 1 word per cycle.
- IDLE, PrRd=1, miss:
  - next edge: latch tag and index, CPU_stall=1, Com_Bus_Req_proc=1, go to MISS_REQ.
  - Victim way: the lowest-index invalid way, else the pLRU victim. Latch the victim way.
- MISS_REQ: wait for Com_Bus_Gnt_proc=1, then go to FILL with beat counter = 0.
- FILL:
  - Address_Com = {tag, index, beat, 2'b00} while granted, else 0.
  - Each cycle with Gnt=1 and Data_in_Bus=1: write Data_Bus_Com into line word[beat]; beat++.
  - Data_in_Bus while Gnt=0 is ignored. If grant drops mid-fill, the counter holds and the request stays asserted.
  - On the beat WORDS-1 write, set tag and valid, update pLRU, Blk_accessed=victim, Com_Bus_Req_proc=0, go to RESP.
- RESP:
  - If PrRd=1: re-look up (now hit), drive word, Rd_valid=1, CPU_stall=0, go to IDLE.
  - If PrRd=0 (request withdrawn): line stays installed, no Rd_valid, CPU_stall=0, go to IDLE.
- FLUSH: clear the valid bits of all ways of set[cnt] and the pLRU bits of that set; cnt++. Takes exactly SETS cycles, then CPU_stall=0 and go to IDLE. Flush is sampled only in IDLE.
- PrRd with Address change during a miss: ignored until RESP (address is latched).
- Multiple-way match (only reachable via a broken bench) is treated as a hit on the lowest way.
- rst mid-FILL: partial line is discarded (valid stays 0) and the request is dropped immediately.

Decomposition:
- Shared package icache_pkg: state enum (IDLE, MISS_REQ, FILL, RESP, FLUSH), a clog2 function, and field-extraction widths/offset constants computed from parameters.
- Sub-module icache_plru:
  - per-set WAYS-1 bit tree with async reset
  - ports: set index, access way + update strobe, victim way output
  - reused by the data cache successor

Test Plan:
- Cold miss at 0x0000_0040, WAYS=4, WORDS=4, grant after 3 cycles, beats 0xA0..0xA3 → Address_Com 0x40, 0x44, 0x48, 0x4C; Rd_valid with 0xA0; Blk_accessed=0. Then read 0x44 → hit, 1-cycle latency, 0xA1.
- Fill 5 tags into index 4 (4 fills, access way 0 again, then a 5th tag) → the 5th fill evicts way 1 per pLRU; a re-read of the way-0 tag still hits.
- Grant deasserted for 2 cycles after beat 1, Data_in_Bus held high → no counter advance during the gap; final line words correct; Com_Bus_Req_proc high until the last beat.
- Flush and PrRd asserted together after 2 lines loaded → CPU_stall high for SETS=16 cycles; the subsequent read of a previously loaded address misses.
- rst pulsed mid-FILL (beat 2) → all outputs 0 asynchronously; the same address read after reset misses and refills correctly.
- PrRd dropped during MISS_REQ → fill completes, no Rd_valid pulse, CPU_stall falls; a later read of that line hits.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and elaboration helpers for the parametrised instruction cache family.
package icache_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MISS_REQ = 3'd1,
    FILL     = 3'd2,
    RESP     = 3'd3,
    FLUSH    = 3'd4
  } state_t;

  // Byte offset inside a 4-byte word; never part of tag/index/offset decode.
  localparam int BYTE_OFF_W = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

endpackage

// File: rtl/icache_block_param_if.sv
// Fetch-port and common-bus signals of the instruction cache, grouped per side.
interface icache_block_param_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAY_W  = 2
);
  logic              PrRd;
  logic [ADDR_W-1:0] Address;
  logic              Flush;
  logic [DATA_W-1:0] Data_Bus;
  logic              Rd_valid;
  logic              CPU_stall;
  logic [WAY_W-1:0]  Blk_accessed;
  logic              Com_Bus_Req_proc;
  logic              Com_Bus_Gnt_proc;
  logic [ADDR_W-1:0] Address_Com;
  logic [DATA_W-1:0] Data_Bus_Com;
  logic              Data_in_Bus;

  modport master (
    output PrRd, Address, Flush, Com_Bus_Gnt_proc, Data_Bus_Com, Data_in_Bus,
    input  Data_Bus, Rd_valid, CPU_stall, Blk_accessed, Com_Bus_Req_proc, Address_Com
  );

  modport slave (
    input  PrRd, Address, Flush, Com_Bus_Gnt_proc, Data_Bus_Com, Data_in_Bus,
    output Data_Bus, Rd_valid, CPU_stall, Blk_accessed, Com_Bus_Req_proc, Address_Com
  );
endinterface

// File: rtl/icache_plru.sv
// Per-set tree pseudo-LRU; the root node selects way bit 0, deeper levels select higher bits.
module icache_plru
  import icache_pkg::*;
#(
  parameter  int WAYS  = 4,
  parameter  int SETS  = 16,
  localparam int WAY_W = max1(clog2(WAYS)),
  localparam int IDX_W = clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] set,
  input  logic             upd,
  input  logic [WAY_W-1:0] upd_way,
  input  logic             clr,
  output logic [WAY_W-1:0] victim
);
  localparam int LVL = clog2(WAYS);

  logic [WAYS-1:1] tree [SETS];
  logic [WAYS-1:1] cur;
  logic [WAYS-1:1] nxt;

  assign cur = tree[set];

  always_comb begin
    logic [WAY_W-1:0] n;
    victim = '0;
    n      = WAY_W'(1);
    for (int d = 0; d < LVL; d++) begin
      victim[d] = cur[n];
      n         = WAY_W'({n, cur[n]});
    end
  end

  // Each node on the accessed path is pointed away from the accessed way.
  always_comb begin
    logic [WAY_W-1:0] n;
    nxt = cur;
    n   = WAY_W'(1);
    for (int d = 0; d < LVL; d++) begin
      nxt[n] = ~upd_way[d];
      n      = WAY_W'({n, upd_way[d]});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) tree[s] <= '0;
    end else if (clr) begin
      tree[set] <= '0;
    end else if (upd) begin
      tree[set] <= nxt;
    end
  end

endmodule

// File: rtl/icache_block_param.sv
// Read-only set-associative L1 instruction cache: 1-cycle hits, burst line refill,
// one outstanding miss, pLRU replacement and a whole-cache flush sequencer.
module icache_block_param
  import icache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int WORDS  = 4
) (
  input logic                 clk,
  input logic                 rst,
  icache_block_param_if.slave bus
);
  localparam int OFF_W   = clog2(WORDS);
  localparam int OFF_WS  = max1(OFF_W);
  localparam int IDX_W   = clog2(SETS);
  localparam int WAY_W   = max1(clog2(WAYS));
  localparam int IDX_LSB = BYTE_OFF_W + OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;

  state_t              state;
  logic [WAYS-1:0]     valid    [SETS];
  logic [TAG_W-1:0]    tag_mem  [SETS][WAYS];
  logic [DATA_W-1:0]   data_mem [SETS][WAYS][WORDS];

  logic [TAG_W-1:0]    tag_q, a_tag;
  logic [IDX_W-1:0]    idx_q, a_idx, flush_cnt;
  logic [OFF_WS-1:0]   off_q, a_off, beat;
  logic [WAY_W-1:0]    vic_q, hit_way, inv_way, plru_vic, plru_way;
  logic [IDX_W-1:0]    plru_set;
  logic                hit, has_inv, plru_upd, beat_ok, fill_last;

  assign a_tag = TAG_W'(bus.Address >> TAG_LSB);
  assign a_idx = IDX_W'(bus.Address >> IDX_LSB);
  assign a_off = (WORDS == 1) ? '0 : OFF_WS'(bus.Address >> BYTE_OFF_W);

  // Descending scan so the lowest matching / lowest invalid way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[a_idx][w] && (tag_mem[a_idx][w] == a_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[a_idx][w]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign beat_ok   = (state == FILL) && bus.Com_Bus_Gnt_proc && bus.Data_in_Bus;
  assign fill_last = beat_ok && (beat == OFF_WS'(WORDS - 1));

  assign plru_set = (state == FLUSH) ? flush_cnt : (state == IDLE) ? a_idx : idx_q;
  assign plru_upd = ((state == IDLE) && bus.PrRd && !bus.Flush && hit) || fill_last;
  assign plru_way = (state == IDLE) ? hit_way : vic_q;

  icache_plru #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk     (clk),
    .rst     (rst),
    .set     (plru_set),
    .upd     (plru_upd),
    .upd_way (plru_way),
    .clr     (state == FLUSH),
    .victim  (plru_vic)
  );

  assign bus.Address_Com = ((state == FILL) && bus.Com_Bus_Gnt_proc)
                         ? ((ADDR_W'(tag_q) << TAG_LSB) | (ADDR_W'(idx_q) << IDX_LSB)
                            | (ADDR_W'(beat) << BYTE_OFF_W))
                         : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
      tag_q     <= '0;
      idx_q     <= '0;
      off_q     <= '0;
      vic_q     <= '0;
      beat      <= '0;
      flush_cnt <= '0;
      bus.Data_Bus         <= '0;
      bus.Rd_valid         <= 1'b0;
      bus.CPU_stall        <= 1'b0;
      bus.Blk_accessed     <= '0;
      bus.Com_Bus_Req_proc <= 1'b0;
    end else begin
      bus.Rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Flush) begin
            state         <= FLUSH;
            flush_cnt     <= '0;
            bus.CPU_stall <= 1'b1;
          end else if (bus.PrRd) begin
            if (hit) begin
              bus.Data_Bus     <= data_mem[a_idx][hit_way][a_off];
              bus.Rd_valid     <= 1'b1;
              bus.Blk_accessed <= hit_way;
            end else begin
              tag_q <= a_tag;
              idx_q <= a_idx;
              off_q <= a_off;
              vic_q <= has_inv ? inv_way : plru_vic;
              bus.CPU_stall        <= 1'b1;
              bus.Com_Bus_Req_proc <= 1'b1;
              state                <= MISS_REQ;
            end
          end
        end
        MISS_REQ: begin
          if (bus.Com_Bus_Gnt_proc) begin
            state <= FILL;
            beat  <= '0;
          end
        end
        FILL: begin
          if (beat_ok) begin
            beat <= beat + 1'b1;
            if (fill_last) begin
              valid[idx_q][vic_q]  <= 1'b1;
              bus.Blk_accessed     <= vic_q;
              bus.Com_Bus_Req_proc <= 1'b0;
              state                <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.PrRd) begin
            bus.Data_Bus <= data_mem[idx_q][vic_q][off_q];
            bus.Rd_valid <= 1'b1;
          end
          bus.CPU_stall <= 1'b0;
          state         <= IDLE;
        end
        FLUSH: begin
          valid[flush_cnt] <= '0;
          flush_cnt        <= flush_cnt + 1'b1;
          if (flush_cnt == IDX_W'(SETS - 1)) begin
            bus.CPU_stall <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage is not reset; a line only becomes visible once its valid bit is set.
  always_ff @(posedge clk) begin
    if (beat_ok) data_mem[idx_q][vic_q][beat] <= bus.Data_Bus_Com;
    if (fill_last) tag_mem[idx_q][vic_q] <= tag_q;
  end

endmodule

// File: tb/tb_icache_block_param.sv
// Scenario bench for icache_block_param: expected fetch words queued at request, checked at Rd_valid.
module tb_icache_block_param;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WAYS   = 4;
  localparam int SETS   = 16;
  localparam int WORDS  = 4;
  localparam int WAY_W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  icache_block_param_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAY_W(WAY_W)) bus ();

  icache_block_param #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q [$];
  logic [31:0] addr_log [$];
  int gnt_delay  = 0;
  int gap_after  = -1;
  int gap_len    = 0;
  int gap_cycles = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= 32'h40 && a <= 32'h4C) return 32'hA0 + ((a - 32'h40) >> 2);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Common-bus arbiter + memory: grants after gnt_delay cycles, optional grant gap.
  initial begin : responder
    int wcnt, nacc, gap_left;
    bus.Com_Bus_Gnt_proc = 1'b0;
    bus.Data_in_Bus      = 1'b0;
    bus.Data_Bus_Com     = '0;
    wcnt = 0; nacc = 0; gap_left = 0;
    forever begin
      @(negedge clk);
      if (rst || !bus.Com_Bus_Req_proc) begin
        bus.Com_Bus_Gnt_proc = 1'b0;
        bus.Data_in_Bus      = 1'b0;
        wcnt = 0; nacc = 0; gap_left = gap_len;
      end else if (wcnt < gnt_delay) begin
        wcnt++;
        bus.Com_Bus_Gnt_proc = 1'b0;
        bus.Data_in_Bus      = 1'b0;
      end else if (nacc == gap_after && gap_left > 0) begin
        gap_left--;
        gap_cycles++;
        bus.Com_Bus_Gnt_proc = 1'b0;
        bus.Data_in_Bus      = 1'b1;
      end else begin
        bus.Com_Bus_Gnt_proc = 1'b1;
        #1;
        bus.Data_in_Bus  = 1'b1;
        bus.Data_Bus_Com = mem_word(bus.Address_Com);
        if (bus.Address_Com != 0) begin
          addr_log.push_back(bus.Address_Com);
          nacc++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [WAY_W-1:0] blk, output int cyc);
    @(negedge clk);
    bus.PrRd    = 1'b1;
    bus.Address = a;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!bus.Rd_valid && cyc < 300);
    d   = bus.Data_Bus;
    blk = bus.Blk_accessed;
    bus.PrRd = 1'b0;
  endtask

  task automatic test_reset();
    bus.PrRd = 1'b0; bus.Flush = 1'b0; bus.Address = '0;
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.Rd_valid !== 1'b0 || bus.CPU_stall !== 1'b0 || bus.Com_Bus_Req_proc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: rd_valid=%b stall=%b req=%b, want all 0",
               bus.Rd_valid, bus.CPU_stall, bus.Com_Bus_Req_proc);
    end
    n_tests++;
    if (bus.Data_Bus !== 32'h0 || bus.Blk_accessed !== 2'd0 || bus.Address_Com !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: data=%h blk=%0d addr_com=%h, want 0",
               bus.Data_Bus, bus.Blk_accessed, bus.Address_Com);
    end
    do_reset();
  endtask

  task automatic test_cold_miss();
    logic [31:0] d, e;
    logic [WAY_W-1:0] b;
    int c;
    bit ok;
    gnt_delay = 3;
    addr_log.delete();
    exp_q.push_back(mem_word(32'h40));
    cpu_read(32'h40, d, b, c);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e || c <= 1) begin
      n_fail++;
      $display("FAIL cold_miss_data: got %h after %0d cycles, want %h after >1", d, c, e);
    end
    n_tests++;
    if (b !== 2'd0) begin
      n_fail++;
      $display("FAIL cold_miss_blk: got %0d, want 0", b);
    end
    ok = (addr_log.size() == 4);
    for (int i = 0; i < addr_log.size() && i < 4; i++)
      if (addr_log[i] !== 32'h40 + 32'(4 * i)) ok = 1'b0;
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cold_miss_beats: %0d beats, first %h, want 4 beats 40,44,48,4c",
               addr_log.size(), (addr_log.size() > 0) ? addr_log[0] : 32'hFFFF_FFFF);
    end
    exp_q.push_back(mem_word(32'h44));
    cpu_read(32'h44, d, b, c);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e || c !== 1) begin
      n_fail++;
      $display("FAIL hit_after_fill: got %h in %0d cycles, want %h in 1", d, c, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 32'h4C - 32'(4 * i);
      bus.PrRd    = 1'b1;
      bus.Address = a;
      exp_q.push_back(mem_word(a));
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_tests++;
      if (bus.Rd_valid !== 1'b1 || bus.Data_Bus !== e) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: rd_valid=%b data=%h, want 1 %h",
                 i, bus.Rd_valid, bus.Data_Bus, e);
      end
    end
    bus.PrRd = 1'b0;
  endtask

  task automatic test_plru();
    logic [31:0] a, d, e;
    logic [WAY_W-1:0] b;
    int c;
    do_reset();
    gnt_delay = 1;
    for (int i = 0; i < 4; i++) begin
      a = 32'h40 + 32'(i << 8);
      exp_q.push_back(mem_word(a));
      cpu_read(a, d, b, c);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e || b !== WAY_W'(i)) begin
        n_fail++;
        $display("FAIL plru_fill[%0d]: data=%h way=%0d, want %h way %0d", i, d, b, e, i);
      end
    end
    exp_q.push_back(mem_word(32'h40));
    cpu_read(32'h40, d, b, c);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e || b !== 2'd0 || c !== 1) begin
      n_fail++;
      $display("FAIL plru_touch0: data=%h way=%0d cyc=%0d, want %h way 0 cyc 1", d, b, c, e);
    end
    exp_q.push_back(mem_word(32'h440));
    cpu_read(32'h440, d, b, c);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e || b !== 2'd1 || c <= 1) begin
      n_fail++;
      $display("FAIL plru_evict: data=%h way=%0d cyc=%0d, want %h way 1 miss", d, b, c, e);
    end
    exp_q.push_back(mem_word(32'h40));
    cpu_read(32'h40, d, b, c);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e || c !== 1) begin
      n_fail++;
      $display("FAIL plru_keep0: data=%h cyc=%0d, want %h in 1", d, c, e);
    end
    exp_q.push_back(mem_word(32'h144));
    cpu_read(32'h144, d, b, c);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e || c <= 1) begin
      n_fail++;
      $display("FAIL plru_evicted_line: data=%h cyc=%0d, want %h as miss", d, c, e);
    end
  endtask

  task automatic test_grant_gap();
    logic [31:0] d, e;
    logic [WAY_W-1:0] b;
    int c;
    bit ok;
    gnt_delay = 0; gap_after = 2; gap_len = 2; gap_cycles = 0;
    addr_log.delete();
    exp_q.push_back(mem_word(32'h1088));
    cpu_read(32'h1088, d, b, c);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e) begin
      n_fail++;
      $display("FAIL gap_data: got %h, want %h", d, e);
    end
    ok = (addr_log.size() == 4);
    for (int i = 0; i < addr_log.size() && i < 4; i++)
      if (addr_log[i] !== 32'h1080 + 32'(4 * i)) ok = 1'b0;
    n_tests++;
    if (!ok || gap_cycles !== 2) begin
      n_fail++;
      $display("FAIL gap_beats: %0d beats, gap cycles with req high %0d, want 4 and 2",
               addr_log.size(), gap_cycles);
    end
    gap_after = -1; gap_len = 0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mem_word(32'h1080 + 32'(4 * i)));
      cpu_read(32'h1080 + 32'(4 * i), d, b, c);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e || c !== 1) begin
        n_fail++;
        $display("FAIL gap_line_word[%0d]: got %h in %0d cycles, want %h in 1", i, d, c, e);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] e;
    int n, rdv, c;
    addr_log.delete();
    @(negedge clk);
    bus.Flush = 1'b1; bus.PrRd = 1'b1; bus.Address = 32'h40;
    exp_q.push_back(mem_word(32'h40));
    @(posedge clk); #1;
    bus.Flush = 1'b0;
    n = 0; rdv = 0;
    while (bus.CPU_stall && n < 100) begin
      n++;
      if (bus.Rd_valid) rdv++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (n !== SETS || rdv !== 0) begin
      n_fail++;
      $display("FAIL flush_len: stall %0d cycles, %0d rd_valid, want %0d and 0", n, rdv, SETS);
    end
    c = 0;
    while (!bus.Rd_valid && c < 300) begin @(posedge clk); #1; c++; end
    bus.PrRd = 1'b0;
    e = exp_q.pop_front();
    n_tests++;
    if (bus.Data_Bus !== e || addr_log.size() !== 4) begin
      n_fail++;
      $display("FAIL flush_then_miss: data=%h beats=%0d, want %h and 4",
               bus.Data_Bus, addr_log.size(), e);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] d, e;
    logic [WAY_W-1:0] b;
    int n, c;
    gnt_delay = 0;
    addr_log.delete();
    @(negedge clk);
    bus.PrRd = 1'b1; bus.Address = 32'h2C0;
    n = 0;
    while (addr_log.size() < 3 && n < 500) begin #1; n++; end
    rst = 1'b1;
    #1;
    n_tests++;
    if (addr_log.size() !== 3) begin
      n_fail++;
      $display("FAIL rst_fill_reach: saw %0d beats before reset, want 3", addr_log.size());
    end
    n_tests++;
    if (bus.Com_Bus_Req_proc !== 1'b0 || bus.CPU_stall !== 1'b0 || bus.Address_Com !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_fill_bus: req=%b stall=%b addr_com=%h, want 0",
               bus.Com_Bus_Req_proc, bus.CPU_stall, bus.Address_Com);
    end
    n_tests++;
    if (bus.Rd_valid !== 1'b0 || bus.Data_Bus !== 32'h0 || bus.Blk_accessed !== 2'd0) begin
      n_fail++;
      $display("FAIL rst_fill_out: rd_valid=%b data=%h blk=%0d, want 0",
               bus.Rd_valid, bus.Data_Bus, bus.Blk_accessed);
    end
    bus.PrRd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    addr_log.delete();
    exp_q.push_back(mem_word(32'h2C8));
    cpu_read(32'h2C8, d, b, c);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e || c <= 1 || addr_log.size() !== 4) begin
      n_fail++;
      $display("FAIL rst_refill: data=%h cyc=%0d beats=%0d, want %h miss 4 beats",
               d, c, addr_log.size(), e);
    end
  endtask

  task automatic test_drop_request();
    logic [31:0] d, e;
    logic [WAY_W-1:0] b;
    logic stall_seen;
    int n, rdv, c;
    gnt_delay = 4;
    addr_log.delete();
    @(negedge clk);
    bus.PrRd = 1'b1; bus.Address = 32'h3D0;
    @(posedge clk); #1;
    bus.PrRd = 1'b0;
    stall_seen = bus.CPU_stall;
    n = 0; rdv = 0;
    while (bus.CPU_stall && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (bus.Rd_valid) rdv++;
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.Rd_valid) rdv++;
    end
    n_tests++;
    if (stall_seen !== 1'b1 || bus.CPU_stall !== 1'b0 || rdv !== 0 || addr_log.size() !== 4) begin
      n_fail++;
      $display("FAIL drop_req: stall_seen=%b stall=%b rd_valid_pulses=%0d beats=%0d, want 1 0 0 4",
               stall_seen, bus.CPU_stall, rdv, addr_log.size());
    end
    exp_q.push_back(mem_word(32'h3D4));
    cpu_read(32'h3D4, d, b, c);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e || c !== 1) begin
      n_fail++;
      $display("FAIL drop_req_hit: got %h in %0d cycles, want %h in 1", d, c, e);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_plru();
    test_grant_gap();
    test_flush();
    test_reset_mid_fill();
    test_drop_request();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
